// File: rtl/ctrl_pipe_unit.sv
// RV32I control decoder with registered EX/MEM/WB control bundles, load-use stall and branch/jump flush.
// Optional illegal-instruction detection on o_ex_illegal is enabled by defining CTRL_ILLEGAL_CHK_EN.
module ctrl_pipe_unit #(
   parameter int ALU_OP_W = 4,
   parameter int LSU_OP_W = 4,
   parameter int MEM_LAT  = 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [31:0]         i_id_instr,
   input  logic                i_id_valid,
   input  logic                i_ex_br_less,
   input  logic                i_ex_br_equal,
   output logic                o_stall,
   output logic                o_ex_valid,
   output logic                o_ex_pc_sel,
   output logic                o_ex_br_un,
   output logic                o_ex_opa_sel,
   output logic                o_ex_opb_sel,
   output logic [ALU_OP_W-1:0] o_ex_alu_op,
   output logic                o_ex_illegal,
   output logic                o_mem_mem_wren,
   output logic [LSU_OP_W-1:0] o_mem_lsu_op,
   output logic                o_wb_rd_wren,
   output logic [1:0]          o_wb_wb_sel,
   output logic [4:0]          o_wb_rd_addr
);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(9);

   localparam logic [LSU_OP_W-1:0] LSU_LB  = LSU_OP_W'(0);
   localparam logic [LSU_OP_W-1:0] LSU_LBU = LSU_OP_W'(1);
   localparam logic [LSU_OP_W-1:0] LSU_LH  = LSU_OP_W'(2);
   localparam logic [LSU_OP_W-1:0] LSU_LHU = LSU_OP_W'(3);
   localparam logic [LSU_OP_W-1:0] LSU_LW  = LSU_OP_W'(4);
   localparam logic [LSU_OP_W-1:0] LSU_SB  = LSU_OP_W'(8);
   localparam logic [LSU_OP_W-1:0] LSU_SH  = LSU_OP_W'(9);
   localparam logic [LSU_OP_W-1:0] LSU_SW  = LSU_OP_W'(10);

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_LSU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   typedef struct packed {
      logic                is_br;
      logic                is_jmp;
      logic                is_ld;
      logic [2:0]          funct3;
      logic                opa_sel;
      logic                opb_sel;
      logic [ALU_OP_W-1:0] alu_op;
      logic                mem_wren;
      logic [LSU_OP_W-1:0] lsu_op;
      logic                rd_wren;
      logic [1:0]          wb_sel;
      logic [4:0]          rd;
   } ex_ctrl_t;

   typedef struct packed {
      logic                mem_wren;
      logic [LSU_OP_W-1:0] lsu_op;
      logic                rd_wren;
      logic [1:0]          wb_sel;
      logic [4:0]          rd;
   } mem_ctrl_t;

   typedef struct packed {
      logic       rd_wren;
      logic [1:0] wb_sel;
      logic [4:0] rd;
   } wb_ctrl_t;

   function automatic ex_ctrl_t ex_bubble();
      ex_ctrl_t r;
      r         = '0;
      r.opb_sel = 1'b1;
      r.lsu_op  = LSU_LW;
      return r;
   endfunction

   // instr[30] picks SUB only for register-register ops; SRA/SRAI use it in both forms.
   function automatic logic [ALU_OP_W-1:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
      case (f3)
         3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [LSU_OP_W-1:0] load_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return LSU_LB;
         3'b001:  return LSU_LH;
         3'b100:  return LSU_LBU;
         3'b101:  return LSU_LHU;
         default: return LSU_LW;
      endcase
   endfunction

   function automatic logic [LSU_OP_W-1:0] store_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return LSU_SB;
         3'b001:  return LSU_SH;
         3'b010:  return LSU_SW;
         default: return LSU_LW;
      endcase
   endfunction

   logic [4:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2;
   ex_ctrl_t   dec_p0;
   logic       recog_p0, use_rs1_p0, use_rs2_p0, ill_p0;

   assign opcode = i_id_instr[6:2];
   assign funct3 = i_id_instr[14:12];
   assign rs1    = i_id_instr[19:15];
   assign rs2    = i_id_instr[24:20];

   always_comb begin
      dec_p0        = ex_bubble();
      dec_p0.funct3 = funct3;
      dec_p0.rd     = i_id_instr[11:7];
      recog_p0      = 1'b1;
      use_rs1_p0    = 1'b1;
      use_rs2_p0    = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_p0.opb_sel = 1'b0;
            dec_p0.alu_op  = alu_sel(funct3, i_id_instr[30], 1'b1);
            dec_p0.rd_wren = 1'b1;
            use_rs2_p0     = 1'b1;
         end
         OPC_OPIMM: begin
            dec_p0.alu_op  = alu_sel(funct3, i_id_instr[30], 1'b0);
            dec_p0.rd_wren = 1'b1;
         end
         OPC_LOAD: begin
            dec_p0.is_ld   = 1'b1;
            dec_p0.lsu_op  = load_op(funct3);
            dec_p0.rd_wren = 1'b1;
            dec_p0.wb_sel  = WB_LSU;
         end
         OPC_STORE: begin
            dec_p0.lsu_op   = store_op(funct3);
            dec_p0.mem_wren = 1'b1;
            use_rs2_p0      = 1'b1;
         end
         OPC_BRANCH: begin
            dec_p0.is_br   = 1'b1;
            dec_p0.opa_sel = 1'b1;
            use_rs2_p0     = 1'b1;
         end
         OPC_JAL: begin
            dec_p0.is_jmp  = 1'b1;
            dec_p0.opa_sel = 1'b1;
            dec_p0.rd_wren = 1'b1;
            dec_p0.wb_sel  = WB_PC4;
            use_rs1_p0     = 1'b0;
         end
         OPC_JALR: begin
            dec_p0.is_jmp  = 1'b1;
            dec_p0.rd_wren = 1'b1;
            dec_p0.wb_sel  = WB_PC4;
         end
         OPC_LUI: begin
            dec_p0.rd_wren = 1'b1;
            dec_p0.wb_sel  = WB_IMM;
            use_rs1_p0     = 1'b0;
         end
         OPC_AUIPC: begin
            dec_p0.opa_sel = 1'b1;
            dec_p0.rd_wren = 1'b1;
            dec_p0.wb_sel  = WB_ALU;
            use_rs1_p0     = 1'b0;
         end
         default: recog_p0 = 1'b0;
      endcase
   end

`ifdef CTRL_ILLEGAL_CHK_EN
   logic bad_fmt_p0;

   always_comb begin
      bad_fmt_p0 = 1'b0;
      case (opcode)
         OPC_LOAD:   bad_fmt_p0 = funct3 inside {3'b011, 3'b110, 3'b111};
         OPC_STORE:  bad_fmt_p0 = funct3 > 3'b010;
         OPC_BRANCH: bad_fmt_p0 = funct3 inside {3'b010, 3'b011};
         OPC_OP:     bad_fmt_p0 = (i_id_instr[31:25] != 7'b0000000) && (i_id_instr[31:25] != 7'b0100000);
         default:    bad_fmt_p0 = 1'b0;
      endcase
   end

   assign ill_p0 = i_id_valid && (!recog_p0 || (i_id_instr[1:0] != 2'b11) || bad_fmt_p0);
`else
   logic unused_instr_bits;
   assign unused_instr_bits = ^{i_id_instr[31], i_id_instr[29:25], i_id_instr[1:0]};
   assign ill_p0            = 1'b0;
`endif

   // ---- EX stage (p1): branch resolution, flush and load-use detection ----
   ex_ctrl_t ex_p1;
   logic     vld_p1, ill_p1, br_taken_p1, pc_sel_p1, ld_use_p1;

   always_comb begin
      case (ex_p1.funct3)
         3'b000:         br_taken_p1 = i_ex_br_equal;
         3'b001:         br_taken_p1 = !i_ex_br_equal;
         3'b100, 3'b110: br_taken_p1 = i_ex_br_less;
         3'b101, 3'b111: br_taken_p1 = !i_ex_br_less;
         default:        br_taken_p1 = 1'b0;
      endcase
   end

   assign pc_sel_p1 = vld_p1 && (ex_p1.is_jmp || (ex_p1.is_br && br_taken_p1));
   assign ld_use_p1 = vld_p1 && ex_p1.is_ld && (ex_p1.rd != 5'd0) && i_id_valid &&
                      ((use_rs1_p0 && (rs1 == ex_p1.rd)) || (use_rs2_p0 && (rs2 == ex_p1.rd)));
   // A redirect discards the ID instruction anyway, so it overrides the stall.
   assign o_stall   = ld_use_p1 && !pc_sel_p1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         vld_p1 <= 1'b0;
         ex_p1  <= ex_bubble();
         ill_p1 <= 1'b0;
      end else begin
         if (pc_sel_p1 || o_stall || !i_id_valid || !recog_p0 || ill_p0) begin
            vld_p1 <= 1'b0;
            ex_p1  <= ex_bubble();
         end else begin
            vld_p1 <= 1'b1;
            ex_p1  <= dec_p0;
         end
         ill_p1 <= ill_p0 && !pc_sel_p1 && !o_stall;
      end
   end

   // ---- MEM stage (p2) ----
   mem_ctrl_t mem_p2;
   logic      vld_p2;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         vld_p2 <= 1'b0;
         mem_p2 <= '{mem_wren: 1'b0, lsu_op: LSU_LW, rd_wren: 1'b0, wb_sel: WB_ALU, rd: 5'd0};
      end else begin
         vld_p2 <= vld_p1;
         mem_p2 <= '{mem_wren: ex_p1.mem_wren, lsu_op: ex_p1.lsu_op, rd_wren: ex_p1.rd_wren,
                     wb_sel: ex_p1.wb_sel, rd: ex_p1.rd};
      end
   end

   // ---- WB stage (p3): MEM_LAT-deep delay line, last entry drives the outputs ----
   wb_ctrl_t wb_p3 [MEM_LAT];
   logic     vld_p3 [MEM_LAT];

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < MEM_LAT; k++) begin
         if (i_reset) begin
            vld_p3[k] <= 1'b0;
            wb_p3[k]  <= '0;
         end else if (k == 0) begin
            vld_p3[k] <= vld_p2;
            wb_p3[k]  <= '{rd_wren: mem_p2.rd_wren, wb_sel: mem_p2.wb_sel, rd: mem_p2.rd};
         end else begin
            vld_p3[k] <= vld_p3[k-1];
            wb_p3[k]  <= wb_p3[k-1];
         end
      end
   end

   assign o_ex_valid     = vld_p1;
   assign o_ex_pc_sel    = pc_sel_p1;
   assign o_ex_br_un     = ex_p1.funct3[1];
   assign o_ex_opa_sel   = ex_p1.opa_sel;
   assign o_ex_opb_sel   = ex_p1.opb_sel;
   assign o_ex_alu_op    = ex_p1.alu_op;
   assign o_ex_illegal   = ill_p1;
   assign o_mem_mem_wren = vld_p2 && mem_p2.mem_wren;
   assign o_mem_lsu_op   = mem_p2.lsu_op;
   assign o_wb_rd_wren   = vld_p3[MEM_LAT-1] && wb_p3[MEM_LAT-1].rd_wren;
   assign o_wb_wb_sel    = wb_p3[MEM_LAT-1].wb_sel;
   assign o_wb_rd_addr   = wb_p3[MEM_LAT-1].rd;

endmodule
